ip_zero_sad: RTL and testbench
==============================

IP_ZERO_SAD -- requirements
Module: ip_zero_sad

Interface
REQ-001 Parameter ACC_W, default 20; SAD accumulator width; SHALL be >= 18.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 arst_n  in  1  asynchronous, active-low reset.
REQ-004 conf_in_rsc_dat  in  13  block config; [1:0] size_idx (0=4x4, 1=8x8, 2=16x16, 3=32x32); [12:2] ignored.
REQ-005 conf_in_rsc_vld / conf_in_rsc_rdy  in / out  1 / 1  conf handshake.
REQ-006 hor_in_rsc_dat  in  32  horizontal-mode prediction, 4 pixels x 8 bit, pixel k in bits [8k+7:8k], raster order.
REQ-007 hor_in_rsc_vld / hor_in_rsc_rdy  in / out  1 / 1.
REQ-008 ver_in_rsc_dat  in  32  vertical-mode prediction, same packing and order as hor_in.
REQ-009 ver_in_rsc_vld / ver_in_rsc_rdy  in / out  1 / 1.
REQ-010 orig_in_rsc_dat  in  32  original pixels, same packing and order.
REQ-011 orig_in_rsc_vld / orig_in_rsc_rdy  in / out  1 / 1.
REQ-012 cost_out_rsc_dat  out  48  [ACC_W-1:0] hor SAD; [ACC_W+19:20] ver SAD; [40] best_ver; other bits 0.
REQ-013 cost_out_rsc_vld / cost_out_rsc_rdy  out / in  1 / 1.

Function
REQ-014 Transfer on any channel SHALL occur exactly on a cycle with vld=1 and rdy=1.
REQ-015 FSM states IDLE, ACCUM, OUTPUT; reset state IDLE.
REQ-016 IDLE: conf_in_rsc_rdy=1; on conf transfer latch size_idx, clear both accumulators, load beat counter with 4<<(2*size_idx) (4/16/64/256 words), go ACCUM.
REQ-017 ACCUM: hor/ver/orig rdy SHALL all equal (hor_vld & ver_vld & orig_vld); the three streams advance only jointly, never individually.
REQ-018 Per joint beat: hor_acc += sum over k of |orig_k - hor_k|; ver_acc += sum over k of |orig_k - ver_k|; differences unsigned 8-bit, per-beat sum 10-bit, zero-extended.
REQ-019 Beat counter decrements per joint beat; on the beat that takes it to 0, go OUTPUT next cycle with final sums registered.
REQ-020 OUTPUT: cost_out_rsc_vld=1, data stable until transfer; best_ver = 1 iff ver SAD < hor SAD (tie -> 0).
REQ-021 On cost_out transfer return to IDLE; conf_in_rsc_rdy SHALL NOT be 1 in the same cycle (one bubble).
REQ-022 Latency: cost_out_rsc_vld rises exactly 1 cycle after the last joint beat.
REQ-023 conf_in_rsc_rdy=0 in ACCUM and OUTPUT; all input rdy=0 outside ACCUM.
REQ-024 Stalls on any input stream or cost_out_rdy SHALL NOT lose or duplicate data; accumulators hold.
REQ-025 Accumulators SHALL NOT overflow for ACC_W>=18 (max 32*32*255 = 261120); no saturation logic.

Reset
REQ-026 arst_n low SHALL immediately force IDLE, accumulators and counter to 0, all vld outputs 0, conf_in_rsc_rdy 0 while reset is held.
REQ-027 After release, conf_in_rsc_rdy=1 from the first clock edge; a reset mid-ACCUM or mid-OUTPUT drops the job with no cost_out.

Verification
REQ-028 4x4, orig all 0x80, hor all 0x7F, ver all 0x80, no stalls -> one cost_out, hor=16, ver=0, best_ver=1, 1 cycle after 4th beat.
REQ-029 32x32, orig 0x00, hor 0xFF, ver 0xFF -> hor=ver=261120, best_ver=0 (tie); exactly 256 joint beats consumed.
REQ-030 8x8 with random vld gaps independently on hor/ver/orig and random cost_out_rdy backpressure -> results equal reference-model SADs; no input accepted while any of three vld low.
REQ-031 16x16 job, arst_n pulsed low after 30 beats, then new 4x4 job -> no output for first job; second job result correct.
REQ-032 Two back-to-back jobs with conf_vld held high -> second conf accepted only from IDLE after first cost_out transfer, with one bubble cycle.

Source files
------------

// File: rtl/ip_zero_sad.sv
// ip_zero_sad: zero-motion SAD cost for horizontal and vertical intra
// predictions of a square block (4x4 .. 32x32), 4 pixels per beat.
// A job is one conf word, then N joint beats of hor/ver/orig words,
// then one cost_out word carrying both SADs and a best-mode flag.
//
// Handshake: on every channel a word moves on exactly the rising edge where
// vld=1 and rdy=1 were both high in the preceding cycle; vld never depends on
// rdy, and a producer holds its data stable while vld=1 and rdy=0.
module ip_zero_sad #(
  // Accumulator width; 18..20 keeps both SAD fields inside their 20-bit slots.
  parameter int ACC_W = 20
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [12:0] conf_in_rsc_dat,
  input  logic        conf_in_rsc_vld,
  output logic        conf_in_rsc_rdy,
  input  logic [31:0] hor_in_rsc_dat,
  input  logic        hor_in_rsc_vld,
  output logic        hor_in_rsc_rdy,
  input  logic [31:0] ver_in_rsc_dat,
  input  logic        ver_in_rsc_vld,
  output logic        ver_in_rsc_rdy,
  input  logic [31:0] orig_in_rsc_dat,
  input  logic        orig_in_rsc_vld,
  output logic        orig_in_rsc_rdy,
  output logic [47:0] cost_out_rsc_dat,
  output logic        cost_out_rsc_vld,
  input  logic        cost_out_rsc_rdy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             live_q;
  logic [8:0]       cnt_q;
  logic [8:0]       cnt_load;
  logic [ACC_W-1:0] hor_acc_q, ver_acc_q;
  logic [9:0]       hor_beat, ver_beat;
  logic             all_vld, beat, conf_xfer, best_ver;
  logic             unused_conf_bits;

  // Only the size index is meaningful in the conf word.
  assign unused_conf_bits = ^conf_in_rsc_dat[12:2];

  // Sum of the four absolute byte differences of one beat.
  function automatic logic [9:0] sad4(input logic [31:0] a, input logic [31:0] b);
    logic [9:0] s;
    logic [7:0] x, y, d;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      x = a[8*k +: 8];
      y = b[8*k +: 8];
      d = (x > y) ? (x - y) : (y - x);
      s = s + {2'b00, d};
    end
    return s;
  endfunction

  assign all_vld   = hor_in_rsc_vld & ver_in_rsc_vld & orig_in_rsc_vld;
  assign beat      = (state_q == ACCUM) & all_vld;
  assign conf_xfer = conf_in_rsc_rdy & conf_in_rsc_vld;
  assign hor_beat  = sad4(orig_in_rsc_dat, hor_in_rsc_dat);
  assign ver_beat  = sad4(orig_in_rsc_dat, ver_in_rsc_dat);
  assign best_ver  = (ver_acc_q < hor_acc_q);
  assign dbg_state = state_q;

  // Beat count per block size: pixels / 4.
  always_comb begin
    cnt_load = 9'd4;
    case (conf_in_rsc_dat[1:0])
      2'd0: cnt_load = 9'd4;
      2'd1: cnt_load = 9'd16;
      2'd2: cnt_load = 9'd64;
      2'd3: cnt_load = 9'd256;
      default: cnt_load = 9'd4;
    endcase
  end

  // live_q stays low through reset so conf is not offered until the first edge after release.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) live_q <= 1'b0;
    else         live_q <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and handshake outputs; the three input streams share one rdy.
  always_comb begin
    state_d          = state_q;
    conf_in_rsc_rdy  = 1'b0;
    hor_in_rsc_rdy   = 1'b0;
    ver_in_rsc_rdy   = 1'b0;
    orig_in_rsc_rdy  = 1'b0;
    cost_out_rsc_vld = 1'b0;
    case (state_q)
      IDLE: begin
        conf_in_rsc_rdy = live_q;
        if (live_q && conf_in_rsc_vld) state_d = ACCUM;
      end
      ACCUM: begin
        hor_in_rsc_rdy  = all_vld;
        ver_in_rsc_rdy  = all_vld;
        orig_in_rsc_rdy = all_vld;
        if (all_vld && cnt_q == 9'd1) state_d = OUTPUT;
      end
      OUTPUT: begin
        cost_out_rsc_vld = 1'b1;
        if (cost_out_rsc_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Accumulators and beat counter: cleared on conf, advanced only on joint beats.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      hor_acc_q <= '0;
      ver_acc_q <= '0;
      cnt_q     <= '0;
    end else if (conf_xfer) begin
      hor_acc_q <= '0;
      ver_acc_q <= '0;
      cnt_q     <= cnt_load;
    end else if (beat) begin
      hor_acc_q <= hor_acc_q + ACC_W'(hor_beat);
      ver_acc_q <= ver_acc_q + ACC_W'(ver_beat);
      cnt_q     <= cnt_q - 9'd1;
    end
  end

  // Result word; accumulators are frozen outside ACCUM so the word is stable in OUTPUT.
  always_comb begin
    cost_out_rsc_dat                = '0;
    cost_out_rsc_dat[ACC_W-1:0]     = hor_acc_q;
    cost_out_rsc_dat[ACC_W+19:20]   = ver_acc_q;
    cost_out_rsc_dat[40]            = best_ver;
  end

endmodule

// File: tb/tb_ip_zero_sad.sv
// Bench for ip_zero_sad: table of uniform-fill jobs with hand-computed SADs,
// then reset-mid-job, back-to-back conf, and random-gap/backpressure jobs.
module tb_ip_zero_sad;

  logic        clk;
  logic        arst_n;
  logic [12:0] conf_in_rsc_dat;
  logic        conf_in_rsc_vld, conf_in_rsc_rdy;
  logic [31:0] hor_in_rsc_dat, ver_in_rsc_dat, orig_in_rsc_dat;
  logic        hor_in_rsc_vld, hor_in_rsc_rdy;
  logic        ver_in_rsc_vld, ver_in_rsc_rdy;
  logic        orig_in_rsc_vld, orig_in_rsc_rdy;
  logic [47:0] cost_out_rsc_dat;
  logic        cost_out_rsc_vld, cost_out_rsc_rdy;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_out_cyc = -1000;

  ip_zero_sad #(.ACC_W(20)) dut (
    .clk(clk), .arst_n(arst_n),
    .conf_in_rsc_dat(conf_in_rsc_dat), .conf_in_rsc_vld(conf_in_rsc_vld), .conf_in_rsc_rdy(conf_in_rsc_rdy),
    .hor_in_rsc_dat(hor_in_rsc_dat), .hor_in_rsc_vld(hor_in_rsc_vld), .hor_in_rsc_rdy(hor_in_rsc_rdy),
    .ver_in_rsc_dat(ver_in_rsc_dat), .ver_in_rsc_vld(ver_in_rsc_vld), .ver_in_rsc_rdy(ver_in_rsc_rdy),
    .orig_in_rsc_dat(orig_in_rsc_dat), .orig_in_rsc_vld(orig_in_rsc_vld), .orig_in_rsc_rdy(orig_in_rsc_rdy),
    .cost_out_rsc_dat(cost_out_rsc_dat), .cost_out_rsc_vld(cost_out_rsc_vld), .cost_out_rsc_rdy(cost_out_rsc_rdy),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [12:0] conf;
    logic [31:0] o, h, v;
    int          eh, ev;
    bit          eb;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ref_sad4(input logic [31:0] a, input logic [31:0] b);
    int s, d;
    s = 0;
    for (int k = 0; k < 4; k++) begin
      d = int'(a[8*k +: 8]) - int'(b[8*k +: 8]);
      s += (d < 0) ? -d : d;
    end
    return s;
  endfunction

  task automatic drive_streams(input logic [31:0] o, input logic [31:0] h, input logic [31:0] v,
                               input bit gaps);
    orig_in_rsc_dat = o;
    hor_in_rsc_dat  = h;
    ver_in_rsc_dat  = v;
    hor_in_rsc_vld  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
    ver_in_rsc_vld  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
    orig_in_rsc_vld = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
  endtask

  // One complete job: conf, beats until cost_out appears, then cost_out drain.
  task automatic run_job(input string tag, input logic [12:0] conf,
                         input logic [31:0] o0, input logic [31:0] h0, input logic [31:0] v0,
                         input int eh, input int ev, input bit eb,
                         input bit gaps, input bit bp, input bit rnd, input bit keep_conf,
                         input int exp_wait);
    int n_words, beats, viol, last_beat, accept_cyc, mh, mv;
    logic [31:0] o, h, v;
    logic [47:0] first_dat;
    bit got;
    n_words = 4 << (2 * int'(conf[1:0]));
    o = o0; h = h0; v = v0;
    if (rnd) begin o = $urandom; h = $urandom; v = $urandom; end
    beats = 0; viol = 0; mh = 0; mv = 0; last_beat = -100; accept_cyc = -100;

    got = 0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(posedge clk); #1;
      conf_in_rsc_dat  = conf;
      conf_in_rsc_vld  = 1'b1;
      cost_out_rsc_rdy = 1'b0;
      drive_streams(o, h, v, 1'b0);
      @(negedge clk);
      if (cost_out_rsc_vld || hor_in_rsc_rdy || ver_in_rsc_rdy || orig_in_rsc_rdy) viol++;
      if (conf_in_rsc_rdy) begin got = 1; accept_cyc = cyc; end
    end
    if (!got) begin
      chk({tag, ".conf_timeout"}, 1, 0);
      conf_in_rsc_vld = 1'b0;
      return;
    end
    if (exp_wait >= 0) chk({tag, ".conf_wait"}, accept_cyc - last_out_cyc, exp_wait);

    got = 0;
    for (int t = 0; t < 3000 && !got; t++) begin
      @(posedge clk); #1;
      conf_in_rsc_vld  = keep_conf;
      cost_out_rsc_rdy = 1'b0;
      drive_streams(o, h, v, gaps);
      @(negedge clk);
      if (conf_in_rsc_rdy) viol++;
      if (hor_in_rsc_rdy != ver_in_rsc_rdy || hor_in_rsc_rdy != orig_in_rsc_rdy) viol++;
      if (hor_in_rsc_rdy && !(hor_in_rsc_vld && ver_in_rsc_vld && orig_in_rsc_vld)) viol++;
      if (cost_out_rsc_vld) got = 1;
      else if (hor_in_rsc_rdy && hor_in_rsc_vld && ver_in_rsc_vld && orig_in_rsc_vld) begin
        beats++;
        mh += ref_sad4(o, h);
        mv += ref_sad4(o, v);
        last_beat = cyc;
        if (rnd) begin o = $urandom; h = $urandom; v = $urandom; end
      end
    end
    if (!got) begin
      chk({tag, ".out_timeout"}, 1, 0);
      return;
    end
    chk({tag, ".beats"}, beats, n_words);
    chk({tag, ".latency"}, cyc - last_beat, 1);

    first_dat = cost_out_rsc_dat;
    got = 0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(posedge clk); #1;
      conf_in_rsc_vld  = keep_conf;
      cost_out_rsc_rdy = bp ? ($urandom_range(0, 2) == 0) : 1'b1;
      @(negedge clk);
      if (!cost_out_rsc_vld || cost_out_rsc_dat !== first_dat) viol++;
      if (conf_in_rsc_rdy || hor_in_rsc_rdy || ver_in_rsc_rdy || orig_in_rsc_rdy) viol++;
      if (cost_out_rsc_rdy) begin got = 1; last_out_cyc = cyc; end
    end
    if (!got) chk({tag, ".drain_timeout"}, 1, 0);
    hor_in_rsc_vld = 1'b0; ver_in_rsc_vld = 1'b0; orig_in_rsc_vld = 1'b0;

    if (rnd) begin eh = mh; ev = mv; eb = (mv < mh); end
    chk({tag, ".hor"}, first_dat[19:0], eh);
    chk({tag, ".ver"}, first_dat[39:20], ev);
    chk({tag, ".best_ver"}, first_dat[40], eb);
    chk({tag, ".pad_bits"}, first_dat[47:41], 0);
    chk({tag, ".protocol"}, viol, 0);
  endtask

  initial begin
    int beats, outs;
    vecs[0] = '{13'h0000, 32'h80808080, 32'h7F7F7F7F, 32'h80808080, 16, 0, 1'b1};
    vecs[1] = '{13'h0003, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 261120, 261120, 1'b0};
    vecs[2] = '{13'h1FFD, 32'h10101010, 32'h20202020, 32'h05050505, 1024, 704, 1'b1};
    vecs[3] = '{13'h0A56, 32'hC8C8C8C8, 32'hC8C8C8C8, 32'h00000000, 0, 51200, 1'b0};
    vecs[4] = '{13'h0000, 32'h00000000, 32'h01010101, 32'h01010101, 16, 16, 1'b0};
    vecs[5] = '{13'h0004, 32'h50505050, 32'h40404040, 32'h20202020, 256, 768, 1'b0};
    vecs[6] = '{13'h0000, 32'h10203040, 32'h11223344, 32'h00000000, 40, 640, 1'b0};
    vecs[7] = '{13'h0005, 32'h80FF0001, 32'h7F00FF00, 32'h80FF0001, 8192, 0, 1'b1};
    vecs[8] = '{13'h0002, 32'hFF00FF00, 32'h00FF00FF, 32'hFF00FF01, 65280, 64, 1'b1};

    arst_n = 1'b0;
    conf_in_rsc_dat = '0; conf_in_rsc_vld = 1'b0;
    hor_in_rsc_dat = '0; ver_in_rsc_dat = '0; orig_in_rsc_dat = '0;
    hor_in_rsc_vld = 1'b0; ver_in_rsc_vld = 1'b0; orig_in_rsc_vld = 1'b0;
    cost_out_rsc_rdy = 1'b0;

    #3;
    chk("rst.conf_rdy", conf_in_rsc_rdy, 0);
    chk("rst.cost_vld", cost_out_rsc_vld, 0);
    chk("rst.in_rdy", {hor_in_rsc_rdy, ver_in_rsc_rdy, orig_in_rsc_rdy}, 0);
    chk("rst.state", dbg_state, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    #1 chk("rel.conf_rdy_before_edge", conf_in_rsc_rdy, 0);
    @(posedge clk); #1;
    chk("rel.conf_rdy_first_edge", conf_in_rsc_rdy, 1);

    for (int i = 0; i < 9; i++)
      run_job($sformatf("vec%0d", i), vecs[i].conf, vecs[i].o, vecs[i].h, vecs[i].v,
              vecs[i].eh, vecs[i].ev, vecs[i].eb, (i % 3 == 2), (i % 2 == 1), 1'b0, 1'b0, -1);

    // Reset in the middle of a 16x16 job.
    @(posedge clk); #1;
    conf_in_rsc_dat = 13'h0002; conf_in_rsc_vld = 1'b1;
    @(negedge clk);
    chk("mid.conf_rdy", conf_in_rsc_rdy, 1);
    beats = 0;
    for (int t = 0; t < 200 && beats < 30; t++) begin
      @(posedge clk); #1;
      conf_in_rsc_vld = 1'b0;
      drive_streams(32'h00000000, 32'h01010101, 32'h02020202, 1'b0);
      @(negedge clk);
      if (hor_in_rsc_rdy) beats++;
    end
    chk("mid.beats30", beats, 30);
    @(posedge clk); #1;
    arst_n = 1'b0;
    #1;
    chk("mid.rst_conf_rdy", conf_in_rsc_rdy, 0);
    chk("mid.rst_cost_vld", cost_out_rsc_vld, 0);
    chk("mid.rst_in_rdy", {hor_in_rsc_rdy, ver_in_rsc_rdy, orig_in_rsc_rdy}, 0);
    repeat (2) @(negedge clk);
    chk("mid.held_conf_rdy", conf_in_rsc_rdy, 0);
    arst_n = 1'b1;
    hor_in_rsc_vld = 1'b0; ver_in_rsc_vld = 1'b0; orig_in_rsc_vld = 1'b0;
    @(posedge clk); #1;
    chk("mid.rel_conf_rdy", conf_in_rsc_rdy, 1);
    outs = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (cost_out_rsc_vld) outs++;
    end
    chk("mid.no_output", outs, 0);
    run_job("after_rst", vecs[0].conf, vecs[0].o, vecs[0].h, vecs[0].v,
            vecs[0].eh, vecs[0].ev, vecs[0].eb, 1'b0, 1'b0, 1'b0, 1'b0, -1);

    // Back-to-back jobs with conf_vld held high throughout.
    run_job("b2b_a", vecs[6].conf, vecs[6].o, vecs[6].h, vecs[6].v,
            vecs[6].eh, vecs[6].ev, vecs[6].eb, 1'b0, 1'b0, 1'b0, 1'b1, -1);
    run_job("b2b_b", vecs[4].conf, vecs[4].o, vecs[4].h, vecs[4].v,
            vecs[4].eh, vecs[4].ev, vecs[4].eb, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    // 8x8 jobs with per-beat random data, random vld gaps and cost_out backpressure.
    for (int i = 0; i < 3; i++)
      run_job($sformatf("rnd%0d", i), 13'h0001, 32'h0, 32'h0, 32'h0,
              0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
